// File: rtl/xadac_axi_arb.sv
// Two-to-one round-robin arbiter for the xadac memory port.
// Write (AW+W) and read (AR) paths arbitrate independently; responses route back by ID MSB.
module xadac_axi_arb #(
   parameter int IdWidth   = 4,
   parameter int AddrWidth = 64,
   parameter int DataWidth = 128,
   parameter int StrbWidth = DataWidth/8
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic [1:0][IdWidth-1:0]        s_aw_id,
   input  logic [1:0][AddrWidth-1:0]      s_aw_addr,
   input  logic [1:0]                     s_aw_valid,
   output logic [1:0]                     s_aw_ready,
   input  logic [1:0][DataWidth-1:0]      s_w_data,
   input  logic [1:0][StrbWidth-1:0]      s_w_strb,
   input  logic [1:0]                     s_w_valid,
   output logic [1:0]                     s_w_ready,
   output logic [1:0][IdWidth-1:0]        s_b_id,
   output logic [1:0]                     s_b_valid,
   input  logic [1:0]                     s_b_ready,
   input  logic [1:0][IdWidth-1:0]        s_ar_id,
   input  logic [1:0][AddrWidth-1:0]      s_ar_addr,
   input  logic [1:0]                     s_ar_valid,
   output logic [1:0]                     s_ar_ready,
   output logic [1:0][IdWidth-1:0]        s_r_id,
   output logic [1:0][DataWidth-1:0]      s_r_data,
   output logic [1:0]                     s_r_valid,
   input  logic [1:0]                     s_r_ready,
   output logic [IdWidth:0]               m_aw_id,
   output logic [AddrWidth-1:0]           m_aw_addr,
   output logic                           m_aw_valid,
   input  logic                           m_aw_ready,
   output logic [DataWidth-1:0]           m_w_data,
   output logic [StrbWidth-1:0]           m_w_strb,
   output logic                           m_w_valid,
   input  logic                           m_w_ready,
   input  logic [IdWidth:0]               m_b_id,
   input  logic                           m_b_valid,
   output logic                           m_b_ready,
   output logic [IdWidth:0]               m_ar_id,
   output logic [AddrWidth-1:0]           m_ar_addr,
   output logic                           m_ar_valid,
   input  logic                           m_ar_ready,
   input  logic [IdWidth:0]               m_r_id,
   input  logic [DataWidth-1:0]           m_r_data,
   input  logic                           m_r_valid,
   output logic                           m_r_ready
);

   typedef enum logic {W_IDLE, W_LOCK} w_state_t;
   typedef enum logic {R_IDLE, R_LOCK} r_state_t;

   w_state_t w_state_reg, w_state_next;
   logic     wgnt_reg, wgnt_next, wptr_reg, wptr_next;
   logic     aw_done_reg, aw_done_next, w_done_reg, w_done_next;
   logic     wsel, aw_hs, w_hs;

   r_state_t r_state_reg, r_state_next;
   logic     rgnt_reg, rgnt_next, rptr_reg, rptr_next;
   logic     rsel, ar_hs;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         w_state_reg <= W_IDLE;
         wgnt_reg    <= 1'b0;
         wptr_reg    <= 1'b0;
         aw_done_reg <= 1'b0;
         w_done_reg  <= 1'b0;
         r_state_reg <= R_IDLE;
         rgnt_reg    <= 1'b0;
         rptr_reg    <= 1'b0;
      end else begin
         w_state_reg <= w_state_next;
         wgnt_reg    <= wgnt_next;
         wptr_reg    <= wptr_next;
         aw_done_reg <= aw_done_next;
         w_done_reg  <= w_done_next;
         r_state_reg <= r_state_next;
         rgnt_reg    <= rgnt_next;
         rptr_reg    <= rptr_next;
      end
   end

   // Write path: AW and W travel as one grant; a split handshake locks the grant.
   always_comb begin
      w_state_next = w_state_reg;
      wgnt_next    = wgnt_reg;
      wptr_next    = wptr_reg;
      aw_done_next = aw_done_reg;
      w_done_next  = w_done_reg;
      m_aw_valid   = 1'b0;
      m_w_valid    = 1'b0;
      s_aw_ready   = 2'b00;
      s_w_ready    = 2'b00;
      wsel         = 1'b0;
      if (w_state_reg == W_IDLE) begin
         wsel = (&s_aw_valid) ? wptr_reg : s_aw_valid[1];
         if (|s_aw_valid) begin
            m_aw_valid       = 1'b1;
            m_w_valid        = s_w_valid[wsel];
            s_aw_ready[wsel] = m_aw_ready;
            s_w_ready[wsel]  = m_w_ready;
         end
      end else begin
         wsel             = wgnt_reg;
         m_aw_valid       = s_aw_valid[wsel] & ~aw_done_reg;
         m_w_valid        = s_w_valid[wsel] & ~w_done_reg;
         s_aw_ready[wsel] = m_aw_ready & ~aw_done_reg;
         s_w_ready[wsel]  = m_w_ready & ~w_done_reg;
      end
      if (!rstn) begin
         m_aw_valid = 1'b0;
         m_w_valid  = 1'b0;
         s_aw_ready = 2'b00;
         s_w_ready  = 2'b00;
      end
      aw_hs = m_aw_valid & m_aw_ready;
      w_hs  = m_w_valid & m_w_ready;
      if (w_state_reg == W_IDLE) begin
         if (m_aw_valid) begin
            if (aw_hs && w_hs) begin
               wptr_next = ~wsel;
            end else begin
               w_state_next = W_LOCK;
               wgnt_next    = wsel;
               aw_done_next = aw_hs;
               w_done_next  = w_hs;
            end
         end
      end else begin
         if ((aw_done_reg | aw_hs) && (w_done_reg | w_hs)) begin
            w_state_next = W_IDLE;
            wptr_next    = ~wgnt_reg;
            aw_done_next = 1'b0;
            w_done_next  = 1'b0;
         end else begin
            aw_done_next = aw_done_reg | aw_hs;
            w_done_next  = w_done_reg | w_hs;
         end
      end
   end

   assign m_aw_id   = {wsel, s_aw_id[wsel]};
   assign m_aw_addr = s_aw_addr[wsel];
   assign m_w_data  = s_w_data[wsel];
   assign m_w_strb  = s_w_strb[wsel];

   always_comb begin
      r_state_next = r_state_reg;
      rgnt_next    = rgnt_reg;
      rptr_next    = rptr_reg;
      m_ar_valid   = 1'b0;
      s_ar_ready   = 2'b00;
      rsel         = 1'b0;
      if (r_state_reg == R_IDLE) begin
         rsel = (&s_ar_valid) ? rptr_reg : s_ar_valid[1];
         m_ar_valid = |s_ar_valid;
      end else begin
         rsel       = rgnt_reg;
         m_ar_valid = s_ar_valid[rsel];
      end
      s_ar_ready[rsel] = m_ar_valid & m_ar_ready;
      if (!rstn) begin
         m_ar_valid = 1'b0;
         s_ar_ready = 2'b00;
      end
      ar_hs = m_ar_valid & m_ar_ready;
      if (r_state_reg == R_IDLE) begin
         if (ar_hs) begin
            rptr_next = ~rsel;
         end else if (m_ar_valid) begin
            r_state_next = R_LOCK;
            rgnt_next    = rsel;
         end
      end else if (ar_hs) begin
         r_state_next = R_IDLE;
         rptr_next    = ~rgnt_reg;
      end
   end

   assign m_ar_id   = {rsel, s_ar_id[rsel]};
   assign m_ar_addr = s_ar_addr[rsel];

   // Response routing is purely combinational on the ID tag bit.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_resp
         assign s_b_valid[gi] = m_b_valid & (m_b_id[IdWidth] == 1'(gi));
         assign s_b_id[gi]    = m_b_id[IdWidth-1:0];
         assign s_r_valid[gi] = m_r_valid & (m_r_id[IdWidth] == 1'(gi));
         assign s_r_id[gi]    = m_r_id[IdWidth-1:0];
         assign s_r_data[gi]  = m_r_data;
      end
   endgenerate

   assign m_b_ready = s_b_ready[m_b_id[IdWidth]];
   assign m_r_ready = s_r_ready[m_r_id[IdWidth]];

endmodule

// File: tb/tb_xadac_axi_arb.sv
// Directed bench for xadac_axi_arb: expected downstream/upstream transfers are queued
// by the stimulus and popped by a negedge monitor whenever the DUT presents one.
module tb_xadac_axi_arb;
   localparam int IW = 4;
   localparam int AW = 64;
   localparam int DW = 128;
   localparam int SW = 16;

   logic clk, rstn;
   logic [1:0][IW-1:0] s_aw_id, s_ar_id, s_b_id, s_r_id;
   logic [1:0][AW-1:0] s_aw_addr, s_ar_addr;
   logic [1:0][DW-1:0] s_w_data, s_r_data;
   logic [1:0][SW-1:0] s_w_strb;
   logic [1:0] s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_b_valid, s_b_ready;
   logic [1:0] s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
   logic [IW:0] m_aw_id, m_b_id, m_ar_id, m_r_id;
   logic [AW-1:0] m_aw_addr, m_ar_addr;
   logic [DW-1:0] m_w_data, m_r_data;
   logic [SW-1:0] m_w_strb;
   logic m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_b_valid, m_b_ready;
   logic m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;

   xadac_axi_arb #(.IdWidth(IW), .AddrWidth(AW), .DataWidth(DW), .StrbWidth(SW)) dut (
      .clk(clk), .rstn(rstn),
      .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
      .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
      .s_b_id(s_b_id), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
      .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
      .s_r_id(s_r_id), .s_r_data(s_r_data), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
      .m_aw_id(m_aw_id), .m_aw_addr(m_aw_addr), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
      .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
      .m_b_id(m_b_id), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
      .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
      .m_r_id(m_r_id), .m_r_data(m_r_data), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [199:0] q_aw[$], q_w[$], q_ar[$], q_r[$], q_b[$];

   localparam logic [DW-1:0] D0 = {16{8'h11}};
   localparam logic [DW-1:0] D1 = {16{8'hD1}};
   localparam logic [DW-1:0] D2 = {8{16'hBEEF}};
   localparam logic [DW-1:0] D3 = {16{8'h33}};
   localparam logic [DW-1:0] D4 = {16{8'h44}};
   localparam logic [DW-1:0] D5 = {16{8'h55}};
   localparam logic [DW-1:0] DA5 = {16{8'hA5}};

   task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      total++;
      bad++;
      $display("FAIL %s: transfer seen with no expected entry", name);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops one expectation per observed transfer.
   always @(negedge clk) begin
      if (rstn) begin
         if (m_aw_valid && m_aw_ready) begin
            if (q_aw.size() == 0) unexpected("aw");
            else chk("aw", 200'({m_aw_id, m_aw_addr}), q_aw.pop_front());
         end
         if (m_w_valid && m_w_ready) begin
            if (q_w.size() == 0) unexpected("w");
            else chk("w", 200'({m_w_data, m_w_strb}), q_w.pop_front());
         end
         if (m_ar_valid && m_ar_ready) begin
            if (q_ar.size() == 0) unexpected("ar");
            else chk("ar", 200'({m_ar_id, m_ar_addr}), q_ar.pop_front());
         end
         for (int k = 0; k < 2; k++) begin
            if (s_r_valid[k]) begin
               if (q_r.size() == 0) unexpected("r");
               else chk("r", 200'({1'(k), s_r_id[k], s_r_data[k]}), q_r.pop_front());
            end
            if (s_b_valid[k]) begin
               if (q_b.size() == 0) unexpected("b");
               else chk("b", 200'({1'(k), s_b_id[k]}), q_b.pop_front());
            end
         end
      end
   end

   initial begin
      rstn = 1'b0;
      s_aw_id = '0; s_aw_addr = '0; s_aw_valid = '0;
      s_w_data = '0; s_w_strb = '0; s_w_valid = '0;
      s_ar_id = '0; s_ar_addr = '0; s_ar_valid = '0;
      s_b_ready = '0; s_r_ready = '0;
      m_aw_ready = 1'b0; m_w_ready = 1'b0; m_ar_ready = 1'b0;
      m_b_id = '0; m_b_valid = 1'b0; m_r_id = '0; m_r_data = '0; m_r_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset holds every downstream valid and upstream ready low.
      s_aw_valid = 2'b11; s_w_valid = 2'b11; s_ar_valid = 2'b11;
      m_aw_ready = 1'b1; m_w_ready = 1'b1; m_ar_ready = 1'b1;
      @(negedge clk);
      chk("rst_m_valid", 200'({m_aw_valid, m_w_valid, m_ar_valid}), 200'(3'b000));
      chk("rst_s_ready", 200'({s_aw_ready, s_w_ready, s_ar_ready}), 200'(6'b0));
      next_cycle();
      s_aw_valid = '0; s_w_valid = '0; s_ar_valid = '0;
      rstn = 1'b1;

      // Single write from requester 1.
      s_aw_id[1] = 4'h3; s_aw_addr[1] = 64'h1000; s_w_data[1] = DA5; s_w_strb[1] = 16'hFFFF;
      s_aw_valid[1] = 1'b1; s_w_valid[1] = 1'b1;
      q_aw.push_back(200'({5'h13, 64'h1000}));
      q_w.push_back(200'({DA5, 16'hFFFF}));
      @(negedge clk);
      chk("single_aw_ready", 200'(s_aw_ready), 200'(2'b10));
      chk("single_w_ready", 200'(s_w_ready), 200'(2'b10));
      chk("single_aw_id", 200'(m_aw_id), 200'(5'h13));
      next_cycle();
      s_aw_valid = '0; s_w_valid = '0;

      // Split write: W stalled three cycles after the AW handshake.
      m_w_ready = 1'b0;
      s_aw_id[1] = 4'h7; s_aw_addr[1] = 64'h2000; s_w_data[1] = D1;
      s_aw_valid[1] = 1'b1; s_w_valid[1] = 1'b1;
      q_aw.push_back(200'({5'h17, 64'h2000}));
      q_w.push_back(200'({D1, 16'hFFFF}));
      @(negedge clk);
      chk("split_first_aw_ready", 200'(s_aw_ready), 200'(2'b10));
      chk("split_first_w_ready", 200'(s_w_ready), 200'(2'b00));
      next_cycle();
      s_aw_valid[1] = 1'b0;
      s_aw_id[0] = 4'h2; s_aw_addr[0] = 64'h3000; s_w_data[0] = D0; s_w_strb[0] = 16'hFFFF;
      s_aw_valid[0] = 1'b1; s_w_valid[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("split_aw_masked", 200'(m_aw_valid), 200'(1'b0));
         chk("split_w_valid", 200'(m_w_valid), 200'(1'b1));
         chk("split_w_data", 200'(m_w_data), 200'(D1));
         chk("split_req0_blocked", 200'(s_aw_ready), 200'(2'b00));
         next_cycle();
      end
      m_w_ready = 1'b1;
      @(negedge clk);
      chk("split_w_done_ready", 200'(s_w_ready), 200'(2'b10));
      chk("split_req0_still_blocked", 200'(s_aw_ready), 200'(2'b00));
      next_cycle();
      s_w_valid[1] = 1'b0;
      q_aw.push_back(200'({5'h02, 64'h3000}));
      q_w.push_back(200'({D0, 16'hFFFF}));
      @(negedge clk);
      chk("split_req0_granted", 200'(s_aw_ready), 200'(2'b01));
      next_cycle();
      s_aw_valid = '0; s_w_valid = '0;

      // Round-robin on AR with both requesters continuously valid.
      s_ar_id[0] = 4'h1; s_ar_addr[0] = 64'hA000;
      s_ar_id[1] = 4'h9; s_ar_addr[1] = 64'hB000;
      s_ar_valid = 2'b11;
      q_ar.push_back(200'({5'h01, 64'hA000}));
      q_ar.push_back(200'({5'h19, 64'hB000}));
      q_ar.push_back(200'({5'h01, 64'hA000}));
      q_ar.push_back(200'({5'h19, 64'hB000}));
      for (int i = 0; i < 4; i++) begin
         logic [1:0] exp_rdy;
         exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
         @(negedge clk);
         chk("rr_ar_ready", 200'(s_ar_ready), 200'(exp_rdy));
         next_cycle();
      end
      s_ar_valid = '0;

      // AR backpressure with requester 1 granted; requester 0 arrives late.
      m_ar_ready = 1'b0;
      s_ar_id[1] = 4'h6; s_ar_addr[1] = 64'hC000;
      s_ar_id[0] = 4'h4; s_ar_addr[0] = 64'hD000;
      s_ar_valid[1] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) s_ar_valid[0] = 1'b1;
         @(negedge clk);
         chk("bp_ar_id", 200'(m_ar_id), 200'(5'h16));
         chk("bp_ar_addr", 200'(m_ar_addr), 200'(64'hC000));
         chk("bp_ar_ready", 200'(s_ar_ready), 200'(2'b00));
         next_cycle();
      end
      m_ar_ready = 1'b1;
      q_ar.push_back(200'({5'h16, 64'hC000}));
      q_ar.push_back(200'({5'h04, 64'hD000}));
      @(negedge clk);
      chk("bp_req1_done", 200'(s_ar_ready), 200'(2'b10));
      next_cycle();
      s_ar_valid[1] = 1'b0;
      @(negedge clk);
      chk("bp_req0_granted", 200'(s_ar_ready), 200'(2'b01));
      next_cycle();
      s_ar_valid = '0;

      // Response routing on R and B.
      m_r_valid = 1'b1; m_r_id = 5'h15; m_r_data = D2; s_r_ready = 2'b01;
      q_r.push_back(200'({1'b1, 4'h5, D2}));
      @(negedge clk);
      chk("route_r_valid", 200'(s_r_valid), 200'(2'b10));
      chk("route_r_ready_blocked", 200'(m_r_ready), 200'(1'b0));
      next_cycle();
      s_r_ready = 2'b10;
      q_r.push_back(200'({1'b1, 4'h5, D2}));
      @(negedge clk);
      chk("route_r_ready", 200'(m_r_ready), 200'(1'b1));
      next_cycle();
      m_r_valid = 1'b0;
      m_b_valid = 1'b1; m_b_id = 5'h02; s_b_ready = 2'b01;
      q_b.push_back(200'({1'b0, 4'h2}));
      @(negedge clk);
      chk("route_b_valid", 200'(s_b_valid), 200'(2'b01));
      chk("route_b_ready", 200'(m_b_ready), 200'(1'b1));
      next_cycle();
      m_b_valid = 1'b0;

      // Reset while in W_LOCK, then confirm the pointer restarts at requester 0.
      m_w_ready = 1'b0;
      s_aw_id[0] = 4'hA; s_aw_addr[0] = 64'h4000; s_w_data[0] = D3;
      s_aw_valid[0] = 1'b1; s_w_valid[0] = 1'b1;
      q_aw.push_back(200'({5'h0A, 64'h4000}));
      @(negedge clk);
      next_cycle();
      s_aw_valid[0] = 1'b0;
      @(negedge clk);
      chk("lock_w_valid", 200'(m_w_valid), 200'(1'b1));
      #2;
      rstn = 1'b0;
      m_w_ready = 1'b1;
      #1;
      chk("midrst_m_valid", 200'({m_aw_valid, m_w_valid}), 200'(2'b00));
      chk("midrst_w_ready", 200'(s_w_ready), 200'(2'b00));
      next_cycle();
      s_w_valid = '0;
      rstn = 1'b1;
      s_aw_id[0] = 4'h1; s_aw_addr[0] = 64'h5000; s_w_data[0] = D4;
      s_aw_id[1] = 4'h2; s_aw_addr[1] = 64'h6000; s_w_data[1] = D5;
      s_aw_valid = 2'b11; s_w_valid = 2'b11;
      q_aw.push_back(200'({5'h01, 64'h5000}));
      q_aw.push_back(200'({5'h12, 64'h6000}));
      q_w.push_back(200'({D4, 16'hFFFF}));
      q_w.push_back(200'({D5, 16'hFFFF}));
      @(negedge clk);
      chk("postrst_first_grant", 200'(s_aw_ready), 200'(2'b01));
      next_cycle();
      s_aw_valid[0] = 1'b0; s_w_valid[0] = 1'b0;
      @(negedge clk);
      chk("postrst_second_grant", 200'(s_aw_ready), 200'(2'b10));
      next_cycle();
      s_aw_valid = '0; s_w_valid = '0;

      repeat (2) next_cycle();
      chk("aw_left", 200'(q_aw.size()), 200'(0));
      chk("w_left", 200'(q_w.size()), 200'(0));
      chk("ar_left", 200'(q_ar.size()), 200'(0));
      chk("r_left", 200'(q_r.size()), 200'(0));
      chk("b_left", 200'(q_b.size()), 200'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/xadac_axi_arb.md
# xadac_axi_arb

Two-to-one arbiter that shares the single xadac memory port (simplified AXI: AW/W/B/AR/R with IDs, single-beat transfers) between two requesters. The two requesters are the xadac load/store unit and a second vector-memory client such as a prefetch or DMA engine. The block performs round-robin arbitration independently on the write path (AW+W as one unit) and the read path (AR). It tags downstream IDs with the source index and routes B/R responses back by that tag.

## Interface
Parameters:
- IdWidth, 4: upstream ID width per requester.
- AddrWidth, 64: address width.
- DataWidth, 128: vector data width.
- StrbWidth, DataWidth/8: write-strobe width.

Ports (m = requester index 0..1; each `s_*` port is a 2-entry array):
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- s_aw_id / s_aw_addr / s_aw_valid  in  2×IdWidth / 2×AddrWidth / 2  per-requester write-address channel.
- s_aw_ready  out  2  per-requester write-address ready.
- s_w_data / s_w_strb / s_w_valid  in  2×DataWidth / 2×StrbWidth / 2  per-requester write-data channel.
- s_w_ready  out  2  per-requester write-data ready.
- s_b_id / s_b_valid  out  2×IdWidth / 2  per-requester write response; s_b_ready  in  2.
- s_ar_id / s_ar_addr / s_ar_valid  in  2×IdWidth / 2×AddrWidth / 2  per-requester read-address channel.
- s_ar_ready  out  2  per-requester read-address ready.
- s_r_id / s_r_data / s_r_valid  out  2×IdWidth / 2×DataWidth / 2  per-requester read data; s_r_ready  in  2.
- m_aw_id  out  IdWidth+1  downstream write ID; MSB = source index.
- m_aw_addr / m_aw_valid  out  AddrWidth / 1;  m_aw_ready  in  1.
- m_w_data / m_w_strb / m_w_valid  out  DataWidth / StrbWidth / 1;  m_w_ready  in  1.
- m_b_id / m_b_valid  in  IdWidth+1 / 1;  m_b_ready  out  1.
- m_ar_id  out  IdWidth+1  downstream read ID; MSB = source index.
- m_ar_addr / m_ar_valid  out  AddrWidth / 1;  m_ar_ready  in  1.
- m_r_id / m_r_data / m_r_valid  in  IdWidth+1 / DataWidth / 1;  m_r_ready  out  1.

## Operation
- Write path FSM, states W_IDLE and W_LOCK. Registers: wgnt (1b), aw_done, w_done, wptr (round-robin priority, 1b).
  - W_IDLE: candidates are the requesters with s_aw_valid. If both are candidates, pick wptr; otherwise pick the sole candidate. The chosen m's AW and W are forwarded downstream combinationally. m_aw_id = {m, s_aw_id[m]}. s_aw_ready[m] = m_aw_ready and s_w_ready[m] = m_w_ready; the non-chosen requester sees ready=0.
  - If AW and W both handshake in the same cycle: stay in W_IDLE and set wptr = ~m.
  - Otherwise: go to W_LOCK with wgnt = m, and record aw_done/w_done for whichever handshake did occur.
  - W_LOCK: forward only requester wgnt. Mask m_aw_valid when aw_done and m_w_valid when w_done. When the last outstanding handshake occurs, go to W_IDLE and set wptr = ~wgnt.
  - s_w_valid without s_aw_valid never requests a grant.
- Read path FSM, states R_IDLE and R_LOCK. Registers: rgnt, rptr. Candidates are the requesters with s_ar_valid; selection and ID tagging are the same as the write path.
  - If the AR handshake completes in the same cycle: stay in R_IDLE and set rptr = ~m.
  - Otherwise: go to R_LOCK with rgnt = m. This holds the granted request stable until m_ar_ready; then return to R_IDLE and set rptr = ~rgnt.
- Response routing (combinational, no state):
  - s_b_valid[k] = m_b_valid and (m_b_id MSB == k); s_b_id[k] = m_b_id low bits; m_b_ready = s_b_ready[MSB].
  - The R channel is routed identically.
  - Responses never block arbitration.
- Read and write paths are fully independent. Simultaneous AW and AR grants in one cycle are allowed.

## Timing
- Reset (rstn low, asynchronous):
  - FSMs go to *_IDLE; wptr = rptr = 0; done flags = 0.
  - All m_*_valid and s_*_ready outputs are 0 while rstn is low, regardless of inputs.
  - Asserting reset mid-transaction abandons it; there is no replay.
- Latency: 0 cycles on all paths (request to downstream valid, downstream ready to upstream ready, response routing). There are no pipeline registers.
- Once m_aw_valid, m_w_valid or m_ar_valid is asserted, it stays asserted with stable payload until its handshake (enforced by the LOCK states).
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,… The first grant after reset goes to requester 0.
- A requester that drops valid before a grant is not remembered.

## Test plan
- Single write: s_aw_valid[1] with addr 0x1000 and id 3, W data 0xA5.., m_aw_ready = m_w_ready = 1 → same cycle m_aw_id = 0x13, m_aw_addr = 0x1000, s_aw_ready[1] = s_w_ready[1] = 1; FSM stays in W_IDLE; wptr = 0.
- Split write: m_w_ready held 0 for 3 cycles after the AW handshake → W_LOCK; m_aw_valid = 0 while m_w_valid stays 1 with stable data; requester 0's AW, raised in the meantime, gets s_aw_ready[0] = 0 until W completes; requester 0 is granted the next cycle.
- Round-robin: both requesters assert AR for 4 consecutive accepted handshakes → m_ar_id MSB sequence 0,1,0,1.
- Backpressure: m_ar_ready = 0 for 5 cycles with requester 1 granted; requester 0 raises AR on cycle 2 → m_ar_addr/m_ar_id stay stable on requester 1's values; requester 0 is granted after the handshake.
- Response routing: m_r_valid with m_r_id = 0x15 and s_r_ready[1] = 0 → s_r_valid[1] = 1, s_r_id[1] = 5, s_r_valid[0] = 0, m_r_ready = 0; same check on B with m_b_id = 0x02 → requester 0.
- Reset mid-operation: drop rstn while in W_LOCK → m_aw_valid = m_w_valid = 0 immediately; after release, the first grant goes to requester 0.
